simd_acc_stage: RTL and testbench

Downstream stage of the 8-bit SIMD multiplier. It consumes the multiplier's 8-bit product word one beat per accepted handshake and accumulates it lane-wise into a 16-bit partitioned accumulator. Lanes are one 8-bit lane, two 4-bit lanes or four 2-bit lanes. When a packet closes, it presents the sums, beat count and per-lane overflow flags through a one-deep valid/ready output register.

---
 rtl/simd_pkg.sv | 31 +++
 rtl/simd_lane_add.sv | 71 +++++++
 rtl/simd_acc_stage.sv | 128 ++++++++++++
 tb/tb_simd_acc_stage.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/simd_pkg.sv
// Shared types and lane-geometry constants for the SIMD accumulator stage.
package simd_pkg;

  typedef enum logic [1:0] {
    LANE8 = 2'b00,
    LANE4 = 2'b01,
    LANE2 = 2'b10
  } simd_mode_t;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } acc_state_t;

  localparam int ACC_W    = 16;
  localparam int DATA_W   = 8;
  localparam int LANE4_FW = 8;
  localparam int LANE4_AW = 4;
  localparam int LANE2_FW = 4;
  localparam int LANE2_AW = 2;

  // Encoding 2'b11 is reserved and behaves as a single 8-bit lane.
  function automatic simd_mode_t decode_mode(input logic [1:0] m);
    case (m)
      2'b01:   return LANE4;
      2'b10:   return LANE2;
      default: return LANE8;
    endcase
  endfunction

endpackage

// File: rtl/simd_lane_add.sv
// Partitioned 16-bit adder: adds zero-extended product lanes into accumulator fields.
// Define SIMD_ACC_SAT_EN to clamp each field at all-ones instead of wrapping.
module simd_lane_add
  import simd_pkg::*;
(
  input  logic [ACC_W-1:0]  acc_i,
  input  logic [DATA_W-1:0] data_i,
  input  simd_mode_t        mode_i,
  output logic [ACC_W-1:0]  sum_o,
  output logic [3:0]        carry_o
);

  logic [ACC_W:0]    s8;
  logic [LANE4_FW:0] s4 [2];
  logic [LANE2_FW:0] s2 [4];
  logic [ACC_W-1:0]  raw;

  always_comb begin
    s8 = {1'b0, acc_i} + {9'b0, data_i};
    for (int k = 0; k < 2; k++)
      s4[k] = {1'b0, acc_i[LANE4_FW*k +: LANE4_FW]} + {5'b0, data_i[LANE4_AW*k +: LANE4_AW]};
    for (int k = 0; k < 4; k++)
      s2[k] = {1'b0, acc_i[LANE2_FW*k +: LANE2_FW]} + {3'b0, data_i[LANE2_AW*k +: LANE2_AW]};
  end

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    raw     = '0;
    carry_o = '0;
    case (mode_i)
      LANE4: begin
        for (int k = 0; k < 2; k++) begin
          raw[LANE4_FW*k +: LANE4_FW] = s4[k][LANE4_FW-1:0];
          carry_o[k]                  = s4[k][LANE4_FW];
        end
      end
      LANE2: begin
        for (int k = 0; k < 4; k++) begin
          raw[LANE2_FW*k +: LANE2_FW] = s2[k][LANE2_FW-1:0];
          carry_o[k]                  = s2[k][LANE2_FW];
        end
      end
      default: begin
        raw        = s8[ACC_W-1:0];
        carry_o[0] = s8[ACC_W];
      end
    endcase
  end

`ifdef SIMD_ACC_SAT_EN
  always_comb begin
    sum_o = raw;
    case (mode_i)
      LANE4: begin
        for (int k = 0; k < 2; k++)
          if (carry_o[k]) sum_o[LANE4_FW*k +: LANE4_FW] = '1;
      end
      LANE2: begin
        for (int k = 0; k < 4; k++)
          if (carry_o[k]) sum_o[LANE2_FW*k +: LANE2_FW] = '1;
      end
      default: begin
        if (carry_o[0]) sum_o = '1;
      end
    endcase
  end
`else
  assign sum_o = raw;
`endif

endmodule

// File: rtl/simd_acc_stage.sv
// Packet accumulator behind the SIMD multiplier: lane-wise sums, beat count and
// overflow flags per packet, emitted through a one-deep valid/ready register.
// Optional clamping of lane fields is enabled with SIMD_ACC_SAT_EN.
module simd_acc_stage
  import simd_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [1:0]        in_mode,
  input  logic              in_first,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic [1:0]        out_mode,
  output logic [CNT_W-1:0]  out_beats,
  output logic [3:0]        out_ovf,
  output logic              drop,
  output logic              proto_err
);

  acc_state_t       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] beats_q, beats_d;
  simd_mode_t       mode_q, mode_d;
  logic [3:0]       ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;
  logic [ACC_W-1:0] out_data_q, out_data_d;
  simd_mode_t       out_mode_q, out_mode_d;
  logic [CNT_W-1:0] out_beats_q, out_beats_d;
  logic [3:0]       out_ovf_q, out_ovf_d;
  logic             drop_q, drop_d;
  logic             perr_q, perr_d;

  logic             accept, opening;
  simd_mode_t       add_mode;
  logic [ACC_W-1:0] add_base, sum;
  logic [3:0]       carry;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  // An accepted in_first mid-packet restarts, so it opens just like a beat in IDLE.
  assign opening  = accept && ((state_q == IDLE) || in_first);
  assign add_mode = opening ? decode_mode(in_mode) : mode_q;
  assign add_base = opening ? '0 : acc_q;

  simd_lane_add u_add (
    .acc_i   (add_base),
    .data_i  (in_data),
    .mode_i  (add_mode),
    .sum_o   (sum),
    .carry_o (carry)
  );

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    beats_d     = beats_q;
    mode_d      = mode_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q && !out_ready;
    out_data_d  = out_data_q;
    out_mode_d  = out_mode_q;
    out_beats_d = out_beats_q;
    out_ovf_d   = out_ovf_q;
    drop_d      = accept && (state_q == ACCUM) && in_first;
    perr_d      = perr_q || (accept && (state_q == IDLE) && !in_first);
    if (accept) begin
      acc_d   = sum;
      mode_d  = add_mode;
      beats_d = opening ? CNT_W'(1) : (&beats_q ? beats_q : beats_q + CNT_W'(1));
      ovf_d   = (opening ? 4'b0 : ovf_q) | carry;
      state_d = in_last ? IDLE : ACCUM;
      if (in_last) begin
        out_valid_d = 1'b1;
        out_data_d  = sum;
        out_mode_d  = add_mode;
        out_beats_d = beats_d;
        out_ovf_d   = ovf_d;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      beats_q     <= '0;
      mode_q      <= LANE8;
      ovf_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_mode_q  <= LANE8;
      out_beats_q <= '0;
      out_ovf_q   <= '0;
      drop_q      <= 1'b0;
      perr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      beats_q     <= beats_d;
      mode_q      <= mode_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_mode_q  <= out_mode_d;
      out_beats_q <= out_beats_d;
      out_ovf_q   <= out_ovf_d;
      drop_q      <= drop_d;
      perr_q      <= perr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_mode  = out_mode_q;
  assign out_beats = out_beats_q;
  assign out_ovf   = out_ovf_q;
  assign drop      = drop_q;
  assign proto_err = perr_q;

endmodule

// File: tb/tb_simd_acc_stage.sv
// Self-checking bench for simd_acc_stage: integer lane-sum reference model compared
// every falling edge, directed vectors with literal expectations, then random traffic.
module tb_simd_acc_stage;

  localparam int CNT_W = 8;
  localparam int BMAX  = (1 << CNT_W) - 1;
`ifdef SIMD_ACC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid, in_first, in_last, out_ready;
  logic [7:0]       in_data;
  logic [1:0]       in_mode;
  logic             in_ready, out_valid, drop, proto_err;
  logic [15:0]      out_data;
  logic [1:0]       out_mode;
  logic [CNT_W-1:0] out_beats;
  logic [3:0]       out_ovf;

  simd_acc_stage #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .in_first  (in_first),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_mode  (out_mode),
    .out_beats (out_beats),
    .out_ovf   (out_ovf),
    .drop      (drop),
    .proto_err (proto_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: unbounded integer sum per lane, output derived from the lane rules.
  int m_sum [4];
  int m_mode, m_beats;
  bit m_inpkt, m_ovalid, m_drop, m_perr;
  int m_odata, m_omode, m_obeats, m_oovf;
  int nl, fw, aw, fmax, v;
  bit m_rdy, m_acc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_sum   = '{0, 0, 0, 0};
      m_mode  = 0; m_beats = 0; m_inpkt = 0;
      m_ovalid = 0; m_drop = 0; m_perr = 0;
      m_odata = 0; m_omode = 0; m_obeats = 0; m_oovf = 0;
    end else begin
      m_rdy  = !m_ovalid || out_ready;
      m_acc  = in_valid && m_rdy;
      m_drop = 0;
      if (out_ready) m_ovalid = 0;
      if (m_acc) begin
        if (!m_inpkt || in_first) begin
          if (m_inpkt) m_drop = 1;
          else if (!in_first) m_perr = 1;
          m_mode  = (in_mode == 2'd3) ? 0 : int'(in_mode);
          m_sum   = '{0, 0, 0, 0};
          m_beats = 0;
        end
        nl = (m_mode == 0) ? 1 : (m_mode == 1) ? 2 : 4;
        fw = 16 / nl;
        aw = 8 / nl;
        fmax = (1 << fw) - 1;
        for (int k = 0; k < nl; k++)
          m_sum[k] += (int'(in_data) >> (k * aw)) & ((1 << aw) - 1);
        m_beats = (m_beats < BMAX) ? m_beats + 1 : BMAX;
        if (in_last) begin
          m_odata = 0;
          m_oovf  = 0;
          for (int k = 0; k < nl; k++) begin
            v = SAT ? ((m_sum[k] > fmax) ? fmax : m_sum[k]) : (m_sum[k] & fmax);
            m_odata |= v << (k * fw);
            if (m_sum[k] > fmax) m_oovf |= 1 << k;
          end
          m_omode  = m_mode;
          m_obeats = m_beats;
          m_ovalid = 1;
          m_inpkt  = 0;
        end else begin
          m_inpkt = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("in_ready",  in_ready,  !m_ovalid || out_ready);
    check("out_valid", out_valid, m_ovalid);
    check("drop",      drop,      m_drop);
    check("proto_err", proto_err, m_perr);
    check("out_data",  out_data,  m_odata & 32'hFFFF);
    check("out_mode",  out_mode,  m_omode);
    check("out_beats", out_beats, m_obeats);
    check("out_ovf",   out_ovf,   m_oovf);
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  // Present one beat and hold it until accepted (bounded).
  task automatic beat(input logic [7:0] d, input logic [1:0] m, input logic f, input logic l);
    int budget = 50;
    in_valid = 1'b1; in_data = d; in_mode = m; in_first = f; in_last = l;
    #1;
    while (!in_ready && budget > 0) begin
      step();
      #1;
      budget--;
    end
    if (budget == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL beat_timeout: in_ready stayed 0 for data 0x%0h", d);
    end
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 0; in_data = 0; in_mode = 0; in_first = 0; in_last = 0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_proto_err", proto_err, 0);
    #1 rst_n = 1'b1;
    step();

    // Mode 00: 0xFF x3
    beat(8'hFF, 2'd0, 1, 0); beat(8'hFF, 2'd0, 0, 0); beat(8'hFF, 2'd0, 0, 1);
    check("m0_valid", out_valid, 1);
    check("m0_data", out_data, 16'h02FD);
    check("m0_beats", out_beats, 3);
    check("m0_ovf", out_ovf, 0);

    // Mode 01: 0xF8, 0x19
    beat(8'hF8, 2'd1, 1, 0); beat(8'h19, 2'd3, 0, 1);
    check("m1_data", out_data, 16'h1011);
    check("m1_ovf", out_ovf, 0);
    check("m1_mode", out_mode, 1);

    // Mode 10: six 0xFF, every lane reaches 18
    for (int i = 0; i < 6; i++) beat(8'hFF, 2'd2, i == 0, i == 5);
    check("m2_data", out_data, SAT ? 16'hFFFF : 16'h2222);
    check("m2_ovf", out_ovf, 4'hF);
    check("m2_beats", out_beats, 6);

    // Backpressure: result held for 5 cycles, next packet waits then loads without bubble
    beat(8'h11, 2'd0, 1, 1);
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h22; in_mode = 2'd0; in_first = 1; in_last = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_in_ready", in_ready, 0);
      check("bp_hold", out_data, 16'h0011);
      step();
    end
    out_ready = 1'b1;
    #1;
    check("bp_release", in_ready, 1);
    step();
    in_valid = 1'b0;
    check("bp_next_valid", out_valid, 1);
    check("bp_next_data", out_data, 16'h0022);

    // Restart inside a packet
    beat(8'h10, 2'd0, 1, 0); beat(8'h05, 2'd0, 1, 1);
    check("rs_drop", drop, 1);
    check("rs_data", out_data, 16'h0005);
    check("rs_beats", out_beats, 1);
    step();
    check("rs_drop_clear", drop, 0);

    // Opening beat without in_first
    check("pe_before", proto_err, 0);
    beat(8'h03, 2'd0, 0, 1);
    check("pe_set", proto_err, 1);
    check("pe_data", out_data, 16'h0003);
    repeat (3) step();
    check("pe_sticky", proto_err, 1);

    // Beat counter saturation
    for (int i = 0; i < 300; i++) beat(8'hFF, 2'd0, i == 0, i == 299);
    check("sat_beats", out_beats, BMAX);
    check("sat_ovf", out_ovf, 1);
    check("sat_data", out_data, SAT ? 16'hFFFF : 16'h2AD4);

    // Asynchronous reset mid-packet
    beat(8'h33, 2'd0, 1, 0);
    #1 rst_n = 1'b0;
    #1;
    check("ar_out_valid", out_valid, 0);
    check("ar_out_data", out_data, 0);
    check("ar_proto_err", proto_err, 0);
    check("ar_in_ready", in_ready, 1);
    step();
    rst_n = 1'b1;
    step();
    beat(8'h07, 2'd0, 1, 1);
    check("ar_fresh", out_data, 16'h0007);
    check("ar_fresh_beats", out_beats, 1);

    // Random traffic against the model
    for (int i = 0; i < 800; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom);
      in_mode   = 2'($urandom_range(0, 3));
      in_first  = ($urandom_range(0, 7) == 0);
      in_last   = ($urandom_range(0, 3) == 0);
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
